// File: rtl/qe_speed_measure_datapath.sv
// Quadrature-encoder speed measurement datapath: accumulator, filter sample counter, result buffer.
// Latency: strobes act on the next rising edge; speed_valid pulses the cycle after load or stall.
// Backpressure: none; all inputs are single-cycle strobes from the speed FSM and are always accepted.
//
// Ports:
//   clk, reset (async, active-low)
//   clear_all, inc_temp_speed_counter, dec_sample_count, do_average, load_speed_buffer : FSM strobes
//   speed_filter_enable, speed_filter_size : filter config, sampled only on clear_all
//   count_overflow, samples_complete       : combinational status back to the FSM
//   speed_value, speed_valid, speed_stalled : published result
//
// ACC_W must be larger than SPEED_W; the published value saturates at 2^SPEED_W-1.
module qe_speed_measure_datapath #(
    parameter int                 SPEED_W        = 16,
    parameter int                 ACC_W          = SPEED_W + 4,
    parameter logic [ACC_W-1:0]   OVERFLOW_LIMIT = {ACC_W{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_all,
    input  logic               inc_temp_speed_counter,
    input  logic               dec_sample_count,
    input  logic               do_average,
    input  logic               load_speed_buffer,
    input  logic               speed_filter_enable,
    input  logic [1:0]         speed_filter_size,
    output logic               count_overflow,
    output logic               samples_complete,
    output logic [SPEED_W-1:0] speed_value,
    output logic               speed_valid,
    output logic               speed_stalled
);

    localparam logic [ACC_W-1:0] SPEED_MAX =
        {{(ACC_W - SPEED_W){1'b0}}, {SPEED_W{1'b1}}};

    logic [ACC_W-1:0] acc;
    logic [4:0]       sample_cnt;
    logic             shadow_en;
    logic [1:0]       shadow_size;

    logic             inc_eff;
    logic             stall_hit;
    logic [SPEED_W-1:0] acc_sat;
    logic [2:0]       avg_shift;

    // Increment only when no higher-priority strobe owns the accumulator.
    assign inc_eff   = inc_temp_speed_counter && !clear_all && !do_average;
    // Only the increment that lands exactly on the limit is a stall event;
    // increments while already saturated are ignored.
    assign stall_hit = inc_eff && (acc == OVERFLOW_LIMIT - ACC_W'(1));
    assign acc_sat   = (acc > SPEED_MAX) ? {SPEED_W{1'b1}} : acc[SPEED_W-1:0];
    // N = 2^(size+1), so divide by N is a right shift of size+1.
    assign avg_shift = {1'b0, shadow_size} + 3'd1;

    assign count_overflow   = (acc == OVERFLOW_LIMIT);
    assign samples_complete = (sample_cnt == 5'd0);

    // Accumulator and shadow configuration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc         <= '0;
            shadow_en   <= 1'b0;
            shadow_size <= 2'd0;
        end else if (clear_all) begin
            acc         <= '0;
            shadow_en   <= speed_filter_enable;
            shadow_size <= speed_filter_size;
        end else if (do_average) begin
            if (shadow_en) begin
                acc <= acc >> avg_shift;
            end
        end else if (inc_temp_speed_counter && (acc != OVERFLOW_LIMIT)) begin
            acc <= acc + ACC_W'(1);
        end
    end

    // Sample counter; a clear in the same cycle as a decrement reloads N.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_cnt <= 5'd0;
        end else if (clear_all) begin
            sample_cnt <= 5'd2 << speed_filter_size;
        end else if (dec_sample_count && (sample_cnt != 5'd0)) begin
            sample_cnt <= sample_cnt - 5'd1;
        end
    end

    // Result buffer. A stall event coinciding with a load wins, since it
    // describes the accumulator state after this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_value   <= '0;
            speed_valid   <= 1'b0;
            speed_stalled <= 1'b0;
        end else begin
            speed_valid <= 1'b0;
            if (stall_hit) begin
                speed_value   <= {SPEED_W{1'b1}};
                speed_stalled <= 1'b1;
                speed_valid   <= 1'b1;
            end else if (load_speed_buffer) begin
                speed_value   <= acc_sat;
                speed_stalled <= 1'b0;
                speed_valid   <= 1'b1;
            end
        end
    end

endmodule

// File: doc/qe_speed_measure_datapath.md
QE_SPEED_MEASURE_DATAPATH -- requirements
Module: qe_speed_measure_datapath

Interface
REQ-001 Parameter SPEED_W, default 16: width of the published speed value.
REQ-002 Parameter ACC_W, default SPEED_W+4: width of the temporary speed counter/accumulator.
REQ-003 Parameter OVERFLOW_LIMIT, default 2^ACC_W-1: accumulator value that signals motor stopped.
REQ-004 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear_all  input  1  one-cycle strobe from the speed FSM: start a new measurement.
REQ-007 inc_temp_speed_counter  input  1  one-cycle strobe: add 1 to the accumulator.
REQ-008 dec_sample_count  input  1  one-cycle strobe: one filter sample finished.
REQ-009 do_average  input  1  one-cycle strobe: divide the accumulator by the sample count.
REQ-010 load_speed_buffer  input  1  one-cycle strobe: publish the result.
REQ-011 speed_filter_enable  input  1  1 = average over N samples.
REQ-012 speed_filter_size  input  2  N select: 00=2, 01=4, 10=8, 11=16.
REQ-013 count_overflow  output  1  to FSM: accumulator at OVERFLOW_LIMIT.
REQ-014 samples_complete  output  1  to FSM: sample counter is 0.
REQ-015 speed_value  output  SPEED_W  last published speed count; larger means slower.
REQ-016 speed_valid  output  1  one-cycle pulse when speed_value updates.
REQ-017 speed_stalled  output  1  sticky: last update was a stall, not a measurement.

Function
REQ-018 clear_all SHALL zero the accumulator, latch speed_filter_enable and speed_filter_size into shadow registers, and load the sample counter with N.
REQ-019 Only the shadow copies SHALL be used until the next clear_all; input changes mid-measurement have no effect.
REQ-020 inc_temp_speed_counter SHALL increment the accumulator by 1 and saturate at OVERFLOW_LIMIT (no wrap).
REQ-021 count_overflow SHALL be combinational: (accumulator == OVERFLOW_LIMIT).
REQ-022 dec_sample_count SHALL decrement the sample counter by 1 and hold at 0 (no wrap).
REQ-023 samples_complete SHALL be combinational: (sample counter == 0), valid in the cycle after the decrement.
REQ-024 do_average SHALL shift the accumulator right by log2(N) (1..4) in one cycle when the shadow filter enable is 1; it SHALL have no effect when the shadow filter enable is 0.
REQ-025 load_speed_buffer SHALL set speed_value to the accumulator, saturated to 2^SPEED_W-1 if it exceeds SPEED_W bits, and SHALL clear speed_stalled.
REQ-026 speed_valid SHALL be high for exactly the cycle after load_speed_buffer (registered, 1-cycle latency).
REQ-027 Stall event: on the first increment that makes the accumulator reach OVERFLOW_LIMIT, the block SHALL set speed_value to all ones, set speed_stalled, and pulse speed_valid, in the next cycle.
REQ-028 Later increments while saturated SHALL NOT repeat the stall event.
REQ-029 Priority when strobes coincide: clear_all > do_average > inc_temp_speed_counter; dec_sample_count and load_speed_buffer act independently.
REQ-030 load_speed_buffer in the same cycle as another strobe SHALL publish the pre-update accumulator value.

Reset
REQ-031 While reset is low: accumulator, sample counter, shadow registers, speed_value, speed_valid and speed_stalled SHALL be 0, immediately and regardless of clk.
REQ-032 Therefore count_overflow = 0 and samples_complete = 1 during and after reset.
REQ-033 Reset asserted mid-measurement SHALL abandon it; the old speed_value SHALL NOT be retained.

Verification
REQ-034 Unfiltered: clear_all, 100 inc strobes, load_speed_buffer -> speed_value=100, speed_valid high 1 cycle, speed_stalled=0.
REQ-035 Filtered, size 01: clear_all; 10+12+14+16 incs with a dec after each sample -> samples_complete after 4th dec; do_average, load -> speed_value=13.
REQ-036 Overflow with OVERFLOW_LIMIT=50: 50 incs -> count_overflow=1, speed_value=0xFFFF, speed_stalled=1, one speed_valid; 10 more incs -> accumulator stays 50, no further pulse.
REQ-037 Same-cycle clear_all and inc with accumulator=20 -> accumulator=0; same-cycle inc and load at 20 -> speed_value=20, accumulator=21.
REQ-038 Size changed 01->11 after clear_all -> samples_complete after 4 decs; average shift stays 2.
REQ-039 Reset pulled low asynchronously with accumulator=37 and speed_value=90 -> all outputs 0 and samples_complete=1 before the next clk edge.
